// File: rtl/pm_entry_pkg.sv
// Shared PM entry definitions: sideband message codes, FSM encoding and clock-rate constants.
package pm_entry_pkg;

    localparam int unsigned MSG_W = 4;

    localparam logic [MSG_W-1:0] MSG_REQ_L1    = 4'd2;
    localparam logic [MSG_W-1:0] MSG_REQ_L2    = 4'd3;
    localparam logic [MSG_W-1:0] MSG_RSP_PMNAK = 4'd9;
    localparam logic [MSG_W-1:0] MSG_RSP_L1    = 4'd10;
    localparam logic [MSG_W-1:0] MSG_RSP_L2    = 4'd11;

    localparam int unsigned CYC_PER_US_100M = 100;
    localparam int unsigned CYC_PER_US_200M = 200;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_REQ = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } pm_state_e;

    function automatic logic [MSG_W-1:0] req_code(input logic l2);
        return l2 ? MSG_REQ_L2 : MSG_REQ_L1;
    endfunction

    function automatic logic [MSG_W-1:0] rsp_code(input logic l2);
        return l2 ? MSG_RSP_L2 : MSG_RSP_L1;
    endfunction

endpackage

// File: rtl/pm_us_timer.sv
// Microsecond timeout timer: prescaler per sideband clock rate feeding a us counter.
module pm_us_timer
    import pm_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_US = 8000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_clk_div_ratio,
    output logic o_expired_c
);

    localparam int unsigned PRE_W = $clog2(CYC_PER_US_200M);
    localparam int unsigned US_W  = $clog2(TIMEOUT_US + 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [US_W-1:0]  us_cnt;
    logic [PRE_W-1:0] pre_last_c;
    logic             wrap_c;

    // Terminal follows the live rate; >= covers a 200->100 MHz switch past the new terminal.
    assign pre_last_c  = i_clk_div_ratio ? PRE_W'(CYC_PER_US_200M - 1) : PRE_W'(CYC_PER_US_100M - 1);
    assign wrap_c      = i_enable && (pre_cnt >= pre_last_c);
    assign o_expired_c = wrap_c && (us_cnt == US_W'(TIMEOUT_US - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else if (i_clear) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else if (i_enable) begin
            if (wrap_c) begin
                pre_cnt <= '0;
                us_cnt  <= us_cnt + US_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/pm_entry_tx.sv
// Requester half of RDI PM entry: sends L1/L2 request, waits for response/PMNAK/timeout.
// Optional PMNAK retry enabled by defining PM_ENTRY_TX_RETRY_EN.
module pm_entry_tx
    import pm_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_US = 8000
`ifdef PM_ENTRY_TX_RETRY_EN
    ,
    parameter int unsigned MAX_RETRY  = 2
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_req_L1_or_L2,
    input  logic             i_clk_div_ratio,
    input  logic             i_msg_done,
    input  logic             i_msg_valid,
    input  logic [MSG_W-1:0] i_msg_no,
    output logic             o_msg_valid,
    output logic [MSG_W-1:0] o_msg_no,
    output logic             o_test_done,
    output logic             o_pm_nak,
    output logic             o_force_exit
);

    pm_state_e state;
    logic      pend_q;
    logic      pend_nak_q;
    logic      rsp_match_c;
    logic      rsp_nak_in_c;
    logic      hit_c;
    logic      nak_c;
    logic      retry_take_c;
    logic      expired_c;
    logic      tmr_run_c;

    // Expected response follows the request code already latched for this flow.
    assign rsp_match_c  = i_msg_valid && (i_msg_no == rsp_code(o_msg_no == MSG_REQ_L2));
    assign rsp_nak_in_c = i_msg_valid && (i_msg_no == MSG_RSP_PMNAK);
    assign hit_c        = pend_q || rsp_match_c || rsp_nak_in_c;
    assign nak_c        = pend_q ? pend_nak_q : rsp_nak_in_c;
    assign tmr_run_c    = i_en && (state == ST_WAIT_RSP);

`ifdef PM_ENTRY_TX_RETRY_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0] retry_cnt;

    assign retry_take_c = nak_c && (retry_cnt < RETRY_W'(MAX_RETRY));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retry_cnt <= '0;
        end else if (!i_en || state == ST_IDLE) begin
            retry_cnt <= '0;
        end else if (state == ST_WAIT_RSP && hit_c && retry_take_c) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end
`else
    assign retry_take_c = 1'b0;
`endif

    pm_us_timer #(
        .TIMEOUT_US (TIMEOUT_US)
    ) u_timer (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_clear         (!tmr_run_c),
        .i_enable        (tmr_run_c),
        .i_clk_div_ratio (i_clk_div_ratio),
        .o_expired_c     (expired_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            o_msg_valid  <= 1'b0;
            o_msg_no     <= '0;
            o_test_done  <= 1'b0;
            o_pm_nak     <= 1'b0;
            o_force_exit <= 1'b0;
            pend_q       <= 1'b0;
            pend_nak_q   <= 1'b0;
        end else begin
            o_force_exit <= 1'b0;
            if (!i_en) begin
                state       <= ST_IDLE;
                o_msg_valid <= 1'b0;
                o_msg_no    <= '0;
                o_test_done <= 1'b0;
                o_pm_nak    <= 1'b0;
                pend_q      <= 1'b0;
                pend_nak_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state       <= ST_SEND_REQ;
                        o_msg_no    <= req_code(i_req_L1_or_L2);
                        o_msg_valid <= 1'b1;
                        pend_q      <= 1'b0;
                    end
                    ST_SEND_REQ: begin
                        // Partner may answer in the same cycle the sideband accepts our request.
                        if (i_msg_done) begin
                            o_msg_valid <= 1'b0;
                            state       <= ST_WAIT_RSP;
                            if (rsp_match_c || rsp_nak_in_c) begin
                                pend_q     <= 1'b1;
                                pend_nak_q <= rsp_nak_in_c;
                            end
                        end
                    end
                    ST_WAIT_RSP: begin
                        pend_q <= 1'b0;
                        if (hit_c) begin
                            if (retry_take_c) begin
                                state       <= ST_SEND_REQ;
                                o_msg_valid <= 1'b1;
                            end else begin
                                state       <= ST_DONE;
                                o_test_done <= 1'b1;
                                o_pm_nak    <= nak_c;
                            end
                        end else if (expired_c) begin
                            state        <= ST_DONE;
                            o_test_done  <= 1'b1;
                            o_pm_nak     <= 1'b1;
                            o_force_exit <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pm_entry_tx.sv
// Scenario bench for pm_entry_tx: flow results go through an expectation queue checked on o_test_done rise.
module tb_pm_entry_tx;
    import pm_entry_pkg::*;

    localparam int unsigned T_US = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_en = 1'b0;
    logic             i_req_L1_or_L2 = 1'b0;
    logic             i_clk_div_ratio = 1'b0;
    logic             i_msg_done = 1'b0;
    logic             i_msg_valid = 1'b0;
    logic [MSG_W-1:0] i_msg_no = '0;
    logic             o_msg_valid;
    logic [MSG_W-1:0] o_msg_no;
    logic             o_test_done;
    logic             o_pm_nak;
    logic             o_force_exit;

    typedef struct {
        bit nak;
        bit force_exit;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic done_prev = 1'b0;

    pm_entry_tx #(
        .TIMEOUT_US (T_US)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_en            (i_en),
        .i_req_L1_or_L2  (i_req_L1_or_L2),
        .i_clk_div_ratio (i_clk_div_ratio),
        .i_msg_done      (i_msg_done),
        .i_msg_valid     (i_msg_valid),
        .i_msg_no        (i_msg_no),
        .o_msg_valid     (o_msg_valid),
        .o_msg_no        (o_msg_no),
        .o_test_done     (o_test_done),
        .o_pm_nak        (o_pm_nak),
        .o_force_exit    (o_force_exit)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    // Result monitor: every o_test_done rise consumes one queued expectation.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_test_done && !done_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done actual=1 required=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (o_pm_nak !== mon_e.nak || o_force_exit !== mon_e.force_exit) begin
                        errors++;
                        $display("FAIL sb_result actual nak=%0b force=%0b required nak=%0b force=%0b",
                                 o_pm_nak, o_force_exit, mon_e.nak, mon_e.force_exit);
                    end
                end
            end else if (o_force_exit) begin
                checks++;
                errors++;
                $display("FAIL sb_stray_force_exit actual=1 required=0");
            end
        end
        done_prev <= o_test_done;
    end

    function automatic logic [7:0] outs();
        return {o_msg_valid, o_msg_no, o_test_done, o_pm_nak, o_force_exit};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic push(input bit nak, input bit fe);
        exp_t e;
        e.nak = nak;
        e.force_exit = fe;
        exp_q.push_back(e);
    endtask

    task automatic wait_req(input logic [MSG_W-1:0] code);
        int cyc = 0;
        while (!o_msg_valid && cyc < 10) begin
            step();
            cyc++;
        end
        checks++;
        if (o_msg_valid !== 1'b1 || o_msg_no !== code) begin
            errors++;
            $display("FAIL req_issue actual valid=%0b no=%0d required valid=1 no=%0d", o_msg_valid, o_msg_no, code);
        end
    endtask

    task automatic send_req(input logic [MSG_W-1:0] code, input int hold);
        wait_req(code);
        step(hold);
        checks++;
        if (o_msg_valid !== 1'b1 || o_msg_no !== code) begin
            errors++;
            $display("FAIL req_hold actual valid=%0b no=%0d required valid=1 no=%0d", o_msg_valid, o_msg_no, code);
        end
        i_msg_done = 1'b1;
        step();
        i_msg_done = 1'b0;
        checks++;
        if (o_msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_drop actual=%0b required=0", o_msg_valid);
        end
    endtask

    task automatic send_rsp(input logic [MSG_W-1:0] code);
        i_msg_valid = 1'b1;
        i_msg_no    = code;
        step();
        i_msg_valid = 1'b0;
        i_msg_no    = '0;
    endtask

    task automatic test_reset();
        i_en = 1'b1;
        step(3);
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs actual=%h required=00", outs());
        end
        i_en = 1'b0;
        i_rst_n = 1'b1;
        step(2);
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL idle_outputs actual=%h required=00", outs());
        end
    endtask

    task automatic test_accept_l1();
        i_req_L1_or_L2 = 1'b0;
        i_en = 1'b1;
        push(1'b0, 1'b0);
        send_req(MSG_REQ_L1, 3);
        step(50);
        checks++;
        if (o_test_done !== 1'b0) begin
            errors++;
            $display("FAIL accept_early_done actual=%0b required=0", o_test_done);
        end
        send_rsp(MSG_RSP_L1);
        checks++;
        if (o_test_done !== 1'b1 || o_pm_nak !== 1'b0) begin
            errors++;
            $display("FAIL accept_latency actual done=%0b nak=%0b required done=1 nak=0", o_test_done, o_pm_nak);
        end
        step(3);
        checks++;
        if (o_test_done !== 1'b1) begin
            errors++;
            $display("FAIL done_held actual=%0b required=1", o_test_done);
        end
        i_en = 1'b0;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL release_outputs actual=%h required=00", outs());
        end
    endtask

    task automatic test_pmnak();
        int reqs = 0;
        i_req_L1_or_L2 = 1'b1;
        i_en = 1'b1;
`ifdef PM_ENTRY_TX_RETRY_EN
        push(1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            send_req(MSG_REQ_L2, 1);
            reqs++;
            step(5);
            send_rsp(r < 2 ? MSG_RSP_PMNAK : MSG_RSP_L2);
        end
        checks++;
        if (reqs != 3 || o_test_done !== 1'b1 || o_pm_nak !== 1'b0) begin
            errors++;
            $display("FAIL retry_result actual reqs=%0d done=%0b nak=%0b required reqs=3 done=1 nak=0", reqs, o_test_done, o_pm_nak);
        end
`else
        push(1'b1, 1'b0);
        send_req(MSG_REQ_L2, 2);
        reqs++;
        step(5);
        send_rsp(MSG_RSP_PMNAK);
        checks++;
        if (o_test_done !== 1'b1 || o_pm_nak !== 1'b1 || o_msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL pmnak_result actual done=%0b nak=%0b valid=%0b required done=1 nak=1 valid=0", o_test_done, o_pm_nak, o_msg_valid);
        end
`endif
        i_en = 1'b0;
        step();
    endtask

    task automatic test_timeout(input bit div, input int exp_cyc);
        int cyc = 0;
        i_clk_div_ratio = div;
        i_req_L1_or_L2 = 1'b0;
        i_en = 1'b1;
        push(1'b1, 1'b1);
        send_req(MSG_REQ_L1, 0);
        while (!o_test_done && cyc < exp_cyc + 20) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != exp_cyc || o_force_exit !== 1'b1 || o_pm_nak !== 1'b1) begin
            errors++;
            $display("FAIL timeout_div%0b actual cyc=%0d force=%0b nak=%0b required cyc=%0d force=1 nak=1", div, cyc, o_force_exit, o_pm_nak, exp_cyc);
        end
        step();
        checks++;
        if (o_force_exit !== 1'b0 || o_test_done !== 1'b1) begin
            errors++;
            $display("FAIL force_pulse actual force=%0b done=%0b required force=0 done=1", o_force_exit, o_test_done);
        end
        i_en = 1'b0;
        i_clk_div_ratio = 1'b0;
        step();
    endtask

    task automatic test_rsp_with_done();
        i_req_L1_or_L2 = 1'b0;
        i_en = 1'b1;
        push(1'b0, 1'b0);
        wait_req(MSG_REQ_L1);
        i_msg_done  = 1'b1;
        i_msg_valid = 1'b1;
        i_msg_no    = MSG_RSP_L1;
        step();
        i_msg_done  = 1'b0;
        i_msg_valid = 1'b0;
        i_msg_no    = '0;
        checks++;
        if (o_test_done !== 1'b0 || o_msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_wait_entry actual done=%0b valid=%0b required done=0 valid=0", o_test_done, o_msg_valid);
        end
        step();
        checks++;
        if (o_test_done !== 1'b1 || o_pm_nak !== 1'b0) begin
            errors++;
            $display("FAIL early_rsp actual done=%0b nak=%0b required done=1 nak=0", o_test_done, o_pm_nak);
        end
        i_en = 1'b0;
        step();
    endtask

    task automatic test_ignore();
        i_req_L1_or_L2 = 1'b0;
        i_en = 1'b1;
        push(1'b0, 1'b0);
        send_req(MSG_REQ_L1, 1);
        send_rsp(MSG_RSP_L2);
        step(2);
        send_rsp(MSG_REQ_L2);
        step(2);
        checks++;
        if (o_test_done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_other actual done=%0b required=0", o_test_done);
        end
        send_rsp(MSG_RSP_L1);
        checks++;
        if (o_test_done !== 1'b1 || o_pm_nak !== 1'b0) begin
            errors++;
            $display("FAIL ignore_then_rsp actual done=%0b nak=%0b required done=1 nak=0", o_test_done, o_pm_nak);
        end
        i_en = 1'b0;
        step();
    endtask

    task automatic test_abort();
        i_req_L1_or_L2 = 1'b0;
        i_en = 1'b1;
        wait_req(MSG_REQ_L1);
        step();
        i_en = 1'b0;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL abort_send actual=%h required=00", outs());
        end
        i_en = 1'b1;
        send_req(MSG_REQ_L1, 1);
        step(20);
        i_en = 1'b0;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL abort_wait actual=%h required=00", outs());
        end
        step(3);
        i_en = 1'b1;
        push(1'b0, 1'b0);
        send_req(MSG_REQ_L1, 1);
        send_rsp(MSG_RSP_L1);
        checks++;
        if (o_test_done !== 1'b1 || o_pm_nak !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart actual done=%0b nak=%0b required done=1 nak=0", o_test_done, o_pm_nak);
        end
        i_en = 1'b0;
        step();
    endtask

    task automatic test_race();
        i_req_L1_or_L2 = 1'b0;
        i_en = 1'b1;
        push(1'b0, 1'b0);
        send_req(MSG_REQ_L1, 0);
        step(100 * T_US - 1);
        send_rsp(MSG_RSP_L1);
        checks++;
        if (o_test_done !== 1'b1 || o_pm_nak !== 1'b0 || o_force_exit !== 1'b0) begin
            errors++;
            $display("FAIL race_rsp_wins actual done=%0b nak=%0b force=%0b required done=1 nak=0 force=0", o_test_done, o_pm_nak, o_force_exit);
        end
        i_en = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        push(1'b0, 1'b0);
        push(1'b0, 1'b0);
        i_req_L1_or_L2 = 1'b1;
        i_en = 1'b1;
        send_req(MSG_REQ_L2, 0);
        send_rsp(MSG_RSP_L2);
        i_en = 1'b0;
        step();
        i_req_L1_or_L2 = 1'b0;
        i_en = 1'b1;
        send_req(MSG_REQ_L1, 0);
        send_rsp(MSG_RSP_L1);
        checks++;
        if (o_test_done !== 1'b1 || o_msg_no !== MSG_REQ_L1) begin
            errors++;
            $display("FAIL b2b_second actual done=%0b no=%0d required done=1 no=%0d", o_test_done, o_msg_no, MSG_REQ_L1);
        end
        i_en = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_accept_l1();
        test_pmnak();
        test_timeout(1'b0, 100 * T_US);
        test_timeout(1'b1, 200 * T_US);
        test_rsp_with_done();
        test_ignore();
        test_abort();
        test_race();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
